// File: rtl/full_adder_pkg.sv
// Shared constants and the 1-bit cell result type for the registered full adder.
package full_adder_pkg;

   localparam int FA_DEFAULT_WIDTH = 1;
   localparam int FA_MAX_WIDTH     = 64;

   typedef struct packed {
      logic c;
      logic s;
   } fa_bit_t;

   function automatic fa_bit_t fa_eval(input logic a, input logic b, input logic ci);
      fa_bit_t r;
      r.s = a ^ b ^ ci;
      r.c = (a & b) | (a & ci) | (b & ci);
      return r;
   endfunction

endpackage

// File: rtl/full_adder_unit_bit.sv
// Combinational 1-bit full-adder cell; one copy per operand bit in full_adder_unit.
module full_adder_bit
   import full_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   fa_bit_t r;

   assign r  = fa_eval(a, b, ci);
   assign s  = r.s;
   assign co = r.c;

endmodule

// File: rtl/full_adder_unit.sv
// Registered ripple-carry adder: {cout,sum} = a + b + cin, one cycle after in_valid.
// Define FULL_ADDER_OVERFLOW_EN to add the registered signed-overflow output ovf.
module full_adder_unit
   import full_adder_pkg::*;
#(
   parameter int WIDTH = FA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef FULL_ADDER_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder_bit u_bit (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (s[i]),
         .co (c[i+1])
      );
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum  <= s;
            cout <= c[WIDTH];
         end
      end
   end

`ifdef FULL_ADDER_OVERFLOW_EN
   // Signed overflow: carry into the MSB differs from carry out of it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (in_valid) begin
         ovf <= c[WIDTH] ^ c[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed and random checks of full_adder_unit at WIDTH = 1, 4, 8 and 16.
// Also checks ovf when FULL_ADDER_OVERFLOW_EN is defined.
module tb_full_adder_unit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic v   = 1'b0;
   logic cin = 1'b0;

   logic        a1 = '0, b1 = '0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] a16 = '0, b16 = '0;

   logic        ov1, ov4, ov8, ov16;
   logic        s1;
   logic [3:0]  s4;
   logic [7:0]  s8;
   logic [15:0] s16;
   logic        co1, co4, co8, co16;
`ifdef FULL_ADDER_OVERFLOW_EN
   logic        of1, of4, of8, of16;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   full_adder_unit #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .in_valid(v), .a(a1), .b(b1), .cin(cin),
      .out_valid(ov1), .sum(s1), .cout(co1)
`ifdef FULL_ADDER_OVERFLOW_EN
      , .ovf(of1)
`endif
   );
   full_adder_unit #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .in_valid(v), .a(a4), .b(b4), .cin(cin),
      .out_valid(ov4), .sum(s4), .cout(co4)
`ifdef FULL_ADDER_OVERFLOW_EN
      , .ovf(of4)
`endif
   );
   full_adder_unit #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .in_valid(v), .a(a8), .b(b8), .cin(cin),
      .out_valid(ov8), .sum(s8), .cout(co8)
`ifdef FULL_ADDER_OVERFLOW_EN
      , .ovf(of8)
`endif
   );
   full_adder_unit #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst(rst), .in_valid(v), .a(a16), .b(b16), .cin(cin),
      .out_valid(ov16), .sum(s16), .cout(co16)
`ifdef FULL_ADDER_OVERFLOW_EN
      , .ovf(of16)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and land 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Signed overflow reference: like-signed operands yielding an opposite-signed sum.
   function automatic logic sovf(input logic am, input logic bm, input logic sm);
      return (am == bm) && (sm != am);
   endfunction

   logic [2:0] tt_in  [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
   logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

   logic [3:0] b2b_a  [3] = '{4'd3, 4'd15, 4'd0};
   logic [3:0] b2b_b  [3] = '{4'd4, 4'd15, 4'd0};
   logic       b2b_c  [3] = '{1'b1, 1'b1, 1'b0};
   logic [4:0] b2b_e  [3] = '{5'h08, 5'h1F, 5'h00};
   logic       b2b_of [3] = '{1'b1, 1'b0, 1'b0};

   initial begin
      // Reset: outputs cleared while rst is held, across clock edges.
      #1 rst = 1'b1;
      v = 1'b1; a1 = 1'b1; b1 = 1'b1; cin = 1'b1;
      step();
      step();
      check("rst_w1", {ov1, co1, s1}, 3'b000);
      check("rst_w16", {ov16, co16, s16}, 18'h0);
      check("rst_w8", {ov8, co8, s8}, 10'h0);
      v = 1'b0;
      rst = 1'b0;

      // Exhaustive 1-bit truth table.
      for (int i = 0; i < 8; i++) begin
         v = 1'b1;
         {a1, b1, cin} = tt_in[i];
         step();
         check($sformatf("tt%0d", i), {ov1, co1, s1}, {1'b1, tt_exp[i]});
`ifdef FULL_ADDER_OVERFLOW_EN
         check($sformatf("tt%0d_ovf", i), of1, tt_exp[i][1] ^ tt_in[i][0]);
`endif
      end

      // One-cycle valid pulse, then hold with changed inputs.
      v = 1'b1; a1 = 1'b1; b1 = 1'b1; cin = 1'b0;
      step();
      check("pulse", {ov1, co1, s1}, 3'b110);
      v = 1'b0; a1 = 1'b0; b1 = 1'b0; cin = 1'b1;
      step();
      check("hold1", {ov1, co1, s1}, 3'b010);
      step();
      check("hold2", {ov1, co1, s1}, 3'b010);

      // Async reset between edges.
      v = 1'b1; a1 = 1'b1; b1 = 1'b1; cin = 1'b1;
      step();
      check("pre_rst", {ov1, co1, s1}, 3'b111);
      v = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("async_rst", {ov1, co1, s1}, 3'b000);
`ifdef FULL_ADDER_OVERFLOW_EN
      check("async_rst_ovf", of1, 1'b0);
`endif
      #1 rst = 1'b0;
      step();
      check("post_rst_idle", {ov1, co1, s1}, 3'b000);
      v = 1'b1; a1 = 1'b0; b1 = 1'b1; cin = 1'b0;
      step();
      check("post_rst", {ov1, co1, s1}, 3'b101);

      // WIDTH=8 boundaries.
      v = 1'b1; a8 = 8'hFF; b8 = 8'h01; cin = 1'b0;
      step();
      check("w8_wrap", {ov8, co8, s8}, {2'b11, 8'h00});
      a8 = 8'h7F; b8 = 8'h01; cin = 1'b0;
      step();
      check("w8_7f", {ov8, co8, s8}, {2'b10, 8'h80});
`ifdef FULL_ADDER_OVERFLOW_EN
      check("w8_7f_ovf", of8, 1'b1);
`endif
      a8 = 8'hFF; b8 = 8'hFF; cin = 1'b1;
      step();
      check("w8_ones", {ov8, co8, s8}, {2'b11, 8'hFF});
      a8 = 8'h00; b8 = 8'h00; cin = 1'b0;
      step();
      check("w8_zero", {ov8, co8, s8}, {2'b10, 8'h00});
      a8 = 8'hFF; b8 = 8'h00; cin = 1'b1;
      step();
      check("w8_cin_wrap", {ov8, co8, s8}, {2'b11, 8'h00});

      // WIDTH=4 back-to-back at full throughput.
      for (int i = 0; i < 3; i++) begin
         v = 1'b1; a4 = b2b_a[i]; b4 = b2b_b[i]; cin = b2b_c[i];
         step();
         check($sformatf("b2b%0d", i), {ov4, co4, s4}, {1'b1, b2b_e[i]});
`ifdef FULL_ADDER_OVERFLOW_EN
         check($sformatf("b2b%0d_ovf", i), of4, b2b_of[i]);
`endif
      end

      // WIDTH=16 random regression against an arithmetic model.
      begin
         logic [16:0] exp_r;
         logic        exp_v;
         logic        exp_o;
         exp_r = {co16, s16};
         exp_o = 1'b0;
`ifdef FULL_ADDER_OVERFLOW_EN
         exp_o = of16;
`endif
         for (int i = 0; i < 1000; i++) begin
            v   = 1'($urandom_range(0, 3) != 0);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            cin = 1'($urandom);
            if (v) begin
               exp_r = 17'(a16) + 17'(b16) + 17'(cin);
               exp_o = sovf(a16[15], b16[15], exp_r[15]);
            end
            exp_v = v;
            step();
            check($sformatf("rnd%0d_v", i), ov16, exp_v);
            check($sformatf("rnd%0d_r", i), {co16, s16}, exp_r);
`ifdef FULL_ADDER_OVERFLOW_EN
            check($sformatf("rnd%0d_ovf", i), of16, exp_o);
`endif
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
